clock_divider_prog: RTL and testbench
=====================================

# clock_divider_prog

Runtime-programmable clock divider that generates a divided square/PWM enable `out_clk` and a one-cycle period `tick` from `in_clk`. It replaces fixed-divisor dividers in the LED/counter designs: divisor and high time are loaded at run time through a shadow register and applied only at period boundaries, so the output never glitches. A run/stop enable and load error flagging are included. `out_clk` is a registered logic signal for downstream enables, not a clock-tree net.

## Interface
- `WIDTH`, 28: width of counter, divisor and high-time registers.
- `DEFAULT_DIV`, 125000000: divisor after reset (in_clk cycles per output period); must be >= 2.
- `DEFAULT_HIGH`, 62500000: out_clk high cycles per period after reset.

- `in_clk` input 1: sole clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: 1 = run, 0 = stop and hold output low.
- `load` input 1: one-cycle strobe; captures `div_in`/`high_in`.
- `div_in` input WIDTH: new divisor; valid range 2..2^WIDTH-1.
- `high_in` input WIDTH: new high time, in cycles.
- `out_clk` output 1: divided output, registered.
- `tick` output 1: one-cycle pulse in the first cycle of each output period.
- `load_busy` output 1: a captured setting is pending, not yet applied.
- `load_err` output 1: one-cycle pulse when a load was rejected.

## Operation
- Active registers: `div_act`, `high_act`, `counter`. Shadow registers: `pend_div`, `pend_high`, plus `pending` flag (= `load_busy`).
- Running (`enable`=1), each edge:
  - counter <= (counter >= div_act-1) ? 0 : counter+1.
  - out_clk <= (counter < high_act).
  - tick <= (counter == 0).
- Result: period = div_act cycles; out_clk high for min(high_act, div_act) cycles, then low. high_act=0 gives constant low. high_act >= div_act gives constant high, and tick still pulses every period.
- Using `>=` in the wrap test recovers from any counter value above div_act-1 in one cycle.
- Load, `load`=1:
  - If div_in < 2: the load is ignored. load_err=1 for the next cycle. Pending state is unchanged.
  - Otherwise: pend_div <= div_in, pend_high <= high_in, pending <= 1. A load while already pending overwrites the shadow; last write wins.
- Apply: on a wrap edge (running, counter >= div_act-1) with pending=1, div_act <= pend_div, high_act <= pend_high, pending <= 0. The new period starts at counter=0 with the new values.
- Load and apply on the same edge: the old shadow is applied, and the new values are captured into the shadow with pending=1.
- Stopped (`enable`=0), each edge: counter <= 0, out_clk <= 0, tick <= 0. A pending setting is applied on that edge, so a stopped divider never keeps load_busy high for more than one cycle. Loads are accepted while stopped.
- Restart: the first running edge sees counter=0. tick and out_clk (if high_act>0) rise together one cycle after enable rises.
- Arithmetic is unsigned, WIDTH bits, with no overflow: counter never exceeds div_act-1 <= 2^WIDTH-2.

## Timing
- Reset values (asynchronous, immediate on rst_n low, including mid-period):
  - counter=0, div_act=DEFAULT_DIV, high_act=DEFAULT_HIGH.
  - pending=0, out_clk=0, tick=0, load_err=0.
- Latency:
  - enable rise to first tick/out_clk high: 1 cycle.
  - load to load_busy high: 1 cycle.
  - load_err: 1 cycle after the rejected load.
- Applied settings take effect on the first cycle after the wrap. The old period always completes in full.
- tick and out_clk rise in the same cycle. tick never exceeds one cycle, except a continuous high when div_act = 1, which cannot occur.

## Test plan
- WIDTH=8, DEFAULT_DIV=10, DEFAULT_HIGH=5, enable=1 from reset release -> out_clk 5 high / 5 low repeating. tick every 10 cycles, coincident with the out_clk rising edge.
- load div_in=4, high_in=1 at mid-period (counter=3) -> load_busy=1. The current 10-cycle period completes. The next periods are 4 cycles, 1 high. load_busy clears at the wrap.
- Two loads before the wrap (6/3, then 8/2), plus a load coincident with a wrap edge -> only 8/2 is applied. The coincident load is applied at the following wrap.
- load div_in=1, and separately div_in=0 -> load_err one-cycle pulse each. Period unchanged. load_busy stays 0.
- high_in=0 and then high_in=20 with div_in=10 -> out_clk constant 0, then constant 1. tick still every 10 cycles.
- enable low mid-period with a pending load, then rst_n pulsed low mid-period -> out_clk=0 and counter=0 on the next edge, and the setting is applied. Reset immediately restores the 10/5 defaults with all outputs 0.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider producing a registered divided enable and a period tick.
// New divisor/high-time settings wait in a shadow register and are applied only at a period boundary.
module clock_divider_prog #(
    parameter int          WIDTH        = 28,
    parameter int unsigned DEFAULT_DIV  = 125000000,
    parameter int unsigned DEFAULT_HIGH = 62500000
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             out_clk,
    output logic             tick,
    output logic             load_busy,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] DIV_RST  = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] HIGH_RST = DEFAULT_HIGH[WIDTH-1:0];

    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] pend_high;
    logic             pending;

    logic             wrap;
    logic             load_ok;
    logic             apply;

    // div_act is always >= 2, so div_act-1 cannot underflow; >= also recovers
    // from any out-of-range counter value in a single cycle.
    always_comb begin
        wrap    = (counter >= (div_act - WIDTH'(1)));
        load_ok = load && (div_in >= WIDTH'(2));
        apply   = pending && (!enable || wrap);
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            div_act   <= DIV_RST;
            high_act  <= HIGH_RST;
            pend_div  <= DIV_RST;
            pend_high <= HIGH_RST;
            pending   <= 1'b0;
            out_clk   <= 1'b0;
            tick      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_err <= load && !load_ok;

            if (enable) begin
                counter <= wrap ? '0 : counter + WIDTH'(1);
                out_clk <= (counter < high_act);
                tick    <= (counter == '0);
            end else begin
                counter <= '0;
                out_clk <= 1'b0;
                tick    <= 1'b0;
            end

            if (apply) begin
                div_act  <= pend_div;
                high_act <= pend_high;
                pending  <= 1'b0;
            end

            // A capture on the apply edge refills the shadow after it has been consumed.
            if (load_ok) begin
                pend_div  <= div_in;
                pend_high <= high_in;
                pending   <= 1'b1;
            end
        end
    end

    assign load_busy = pending;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed, table-driven bench for clock_divider_prog (WIDTH=8, defaults 10/5).
// Each table row is one rising edge: inputs driven before it, outputs expected after it.
module tb_clock_divider_prog;

    logic       in_clk;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [7:0] div_in;
    logic [7:0] high_in;
    logic       out_clk;
    logic       tick;
    logic       load_busy;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_prog #(
        .WIDTH       (8),
        .DEFAULT_DIV (10),
        .DEFAULT_HIGH(5)
    ) dut (
        .in_clk   (in_clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .load     (load),
        .div_in   (div_in),
        .high_in  (high_in),
        .out_clk  (out_clk),
        .tick     (tick),
        .load_busy(load_busy),
        .load_err (load_err)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] div;
        logic [7:0] high;
        logic       out;
        logic       tick;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    // Appends n running edges; pattern bits are written left-to-right in time order.
    function automatic void add_seg(int n, logic [15:0] o, logic [15:0] t, logic [15:0] b);
        vec_t v;
        for (int j = 0; j < n; j++) begin
            v.en   = 1'b1;
            v.ld   = 1'b0;
            v.div  = 8'd0;
            v.high = 8'd0;
            v.out  = o[n-1-j];
            v.tick = t[n-1-j];
            v.busy = b[n-1-j];
            v.err  = 1'b0;
            vecs.push_back(v);
        end
    endfunction

    function automatic void set_load(int edge_no, logic [7:0] d, logic [7:0] h);
        vec_t v;
        v      = vecs[edge_no-1];
        v.ld   = 1'b1;
        v.div  = d;
        v.high = h;
        vecs[edge_no-1] = v;
    endfunction

    function automatic void mark_err(int edge_no);
        vec_t v;
        v     = vecs[edge_no-1];
        v.err = 1'b1;
        vecs[edge_no-1] = v;
    endfunction

    function automatic void set_stop(int edge_no);
        vec_t v;
        v    = vecs[edge_no-1];
        v.en = 1'b0;
        vecs[edge_no-1] = v;
    endfunction

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %b, want %b", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        div_in  = 8'd0;
        high_in = 8'd0;

        // edges 1-20: default 10/5; load 4/1 at counter=3 (edge 14), applied at wrap (edge 20)
        add_seg(10, 16'b1111100000, 16'b1000000000, 16'b0000000000);
        add_seg(10, 16'b1111100000, 16'b1000000000, 16'b0001111110);
        // edges 21-28: 4/1
        add_seg(8,  16'b10001000,   16'b10001000,   16'b00000000);
        // edges 29-32: load 6/3, then 8/2, then 10/5 on the wrap edge
        add_seg(4,  16'b1000,       16'b1000,       16'b1111);
        // edges 33-40: 8/2 with 10/5 pending
        add_seg(8,  16'b11000000,   16'b10000000,   16'b11111110);
        // edges 41-60: back to 10/5; rejected loads at 51 and 53
        add_seg(10, 16'b1111100000, 16'b1000000000, 16'b0000000000);
        add_seg(10, 16'b1111100000, 16'b1000000000, 16'b0000000000);
        // edges 61-90: high 0 then high 20
        add_seg(10, 16'b1111100000, 16'b1000000000, 16'b1111111110);
        add_seg(10, 16'b0000000000, 16'b1000000000, 16'b1111111110);
        add_seg(10, 16'b1111111111, 16'b1000000000, 16'b0000000000);
        // edges 91-94: load 4/2, stop (applies 4/2, captures 6/3), stopped edge applies 6/3
        add_seg(4,  16'b1100,       16'b1000,       16'b0110);
        // edges 95-102: restart with 6/3, then a load left pending for the reset check
        add_seg(8,  16'b11100011,   16'b10000010,   16'b00000001);

        set_load(14, 8'd4, 8'd1);
        set_load(29, 8'd6, 8'd3);
        set_load(30, 8'd8, 8'd2);
        set_load(32, 8'd10, 8'd5);
        set_load(51, 8'd1, 8'd3);
        set_load(53, 8'd0, 8'd3);
        set_load(61, 8'd10, 8'd0);
        set_load(71, 8'd10, 8'd20);
        set_load(92, 8'd4, 8'd2);
        set_load(93, 8'd6, 8'd3);
        set_load(102, 8'd4, 8'd1);
        mark_err(51);
        mark_err(53);
        set_stop(93);
        set_stop(94);

        @(negedge in_clk);
        check("rst_out_clk", 0, out_clk, 1'b0);
        check("rst_tick", 0, tick, 1'b0);
        check("rst_load_busy", 0, load_busy, 1'b0);
        check("rst_load_err", 0, load_err, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable  = vecs[i].en;
            load    = vecs[i].ld;
            div_in  = vecs[i].div;
            high_in = vecs[i].high;
            @(negedge in_clk);
            check("out_clk", i + 1, out_clk, vecs[i].out);
            check("tick", i + 1, tick, vecs[i].tick);
            check("load_busy", i + 1, load_busy, vecs[i].busy);
            check("load_err", i + 1, load_err, vecs[i].err);
        end
        load    = 1'b0;
        div_in  = 8'd0;
        high_in = 8'd0;
        enable  = 1'b1;

        // Asynchronous reset mid-period, with out_clk high and a setting pending.
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_clk", 0, out_clk, 1'b0);
        check("arst_tick", 0, tick, 1'b0);
        check("arst_load_busy", 0, load_busy, 1'b0);
        check("arst_load_err", 0, load_err, 1'b0);
        @(negedge in_clk);
        check("held_rst_out_clk", 0, out_clk, 1'b0);
        rst_n = 1'b1;

        // Defaults restored: 10-cycle period, 5 high, pending load discarded.
        for (int k = 0; k < 11; k++) begin
            @(negedge in_clk);
            check("dflt_out_clk", k, out_clk, ((k % 10) < 5) ? 1'b1 : 1'b0);
            check("dflt_tick", k, tick, ((k % 10) == 0) ? 1'b1 : 1'b0);
            check("dflt_load_busy", k, load_busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
